// File: rtl/mfp_ahb_lite_pkg.sv
// Shared AHB-Lite definitions for the command master.
//   htrans_e   : HTRANS codes (IDLE, BUSY, NONSEQ, SEQ)
//   size_e     : 2-bit transfer size codes (byte, half, word)
//   ahb_cmd_t  : one command record {write, addr, size, wdata}
//   norm_size  : maps size code 3 onto word
//   align_addr : clears the address bits below the transfer size
package mfp_ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } ahb_cmd_t;

    function automatic logic [1:0] norm_size(logic [1:0] size);
        return (size == 2'd3) ? SIZE_WORD : size;
    endfunction

    function automatic logic [31:0] align_addr(logic [31:0] addr, logic [1:0] size);
        logic [31:0] a;
        a = addr;
        case (size)
            SIZE_HALF: a[0]   = 1'b0;
            SIZE_WORD: a[1:0] = 2'b00;
            default:   a      = addr;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_lane_align.sv
// Byte-lane handling between the command stream and the AHB data buses.
// Purely combinational.
// Build option: MFP_AHB_MASTER_LANES_EN
//   defined   : write data replicated across lanes by size; read data shifted
//               down by the data-phase address and zero-extended to the size
//   undefined : both paths pass through unmodified
// Ports:
//   wr_size, wr_data_in -> wr_data_out           (command side, normalised size)
//   rd_size, rd_addr_lo, rd_data_in -> rd_data_out (data-phase side)
module mfp_ahb_lite_lane_align
    import mfp_ahb_lite_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data_in,
    output logic [31:0] wr_data_out,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_addr_lo,
    input  logic [31:0] rd_data_in,
    output logic [31:0] rd_data_out
);

`ifdef MFP_AHB_MASTER_LANES_EN
    logic [31:0] rd_shifted;

    always_comb begin
        case (wr_size)
            SIZE_BYTE: wr_data_out = {4{wr_data_in[7:0]}};
            SIZE_HALF: wr_data_out = {2{wr_data_in[15:0]}};
            default:   wr_data_out = wr_data_in;
        endcase

        rd_shifted = rd_data_in >> {rd_addr_lo, 3'b000};
        case (rd_size)
            SIZE_BYTE: rd_data_out = {24'h0, rd_shifted[7:0]};
            SIZE_HALF: rd_data_out = {16'h0, rd_shifted[15:0]};
            default:   rd_data_out = rd_shifted;
        endcase
    end
`else
    assign wr_data_out = wr_data_in;
    assign rd_data_out = rd_data_in;

    // Lane controls have no effect in the pass-through build.
    logic unused_lane_ctrl;
    assign unused_lane_ctrl = ^{wr_size, rd_size, rd_addr_lo};
`endif

endmodule

// File: rtl/mfp_ahb_lite_cmd_master.sv
// AHB-Lite initiator: valid/ready command stream -> single NONSEQ transfers,
// with pipelined address and data phases (one command per cycle, zero-wait).
// Build option: MFP_AHB_MASTER_LANES_EN (byte-lane replication / extraction,
// see mfp_ahb_lite_lane_align).
// Ports:
//   HCLK, HRESETn                      clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_*          command stream in
//   rsp_valid/rsp_rdata/rsp_err        one-cycle in-order response pulse
//   busy                               any command in flight or held
//   H*                                 AHB-Lite initiator interface
module mfp_ahb_lite_cmd_master
    import mfp_ahb_lite_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    logic        ap_valid;
    logic [31:0] ap_wdata;
    logic        dp_valid;
    logic        dp_write;
    logic [1:0]  dp_addr_lo;
    logic [1:0]  dp_size;
    logic        hold_valid;
    ahb_cmd_t    hold_cmd;

    logic [1:0]  cmd_size_n;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    ahb_cmd_t    new_cmd;
    ahb_cmd_t    ap_cmd;
    ahb_cmd_t    ap_load_cmd;
    logic        err_first;
    logic        accept;
    logic        ap_load;

    mfp_ahb_lite_lane_align u_lane_align (
        .wr_size     (cmd_size_n),
        .wr_data_in  (cmd_wdata),
        .wr_data_out (lane_wdata),
        .rd_size     (dp_size),
        .rd_addr_lo  (dp_addr_lo),
        .rd_data_in  (HRDATA),
        .rd_data_out (lane_rdata)
    );

    assign cmd_size_n  = norm_size(cmd_size);
    assign new_cmd     = {cmd_write, align_addr(cmd_addr, cmd_size_n), cmd_size_n, lane_wdata};
    assign ap_cmd      = {HWRITE, HADDR, HSIZE[1:0], ap_wdata};
    assign ap_load_cmd = hold_valid ? hold_cmd : new_cmd;

    // First cycle of a two-cycle ERROR response.
    assign err_first = dp_valid & HRESP & ~HREADY;
    assign cmd_ready = (HREADY | ~ap_valid) & ~hold_valid & ~err_first;
    assign accept    = cmd_valid & cmd_ready;

    // A held command always wins over a new one; an empty address phase may
    // be filled during a wait state.
    assign ap_load = HREADY ? (hold_valid | accept) : (~err_first & ~ap_valid & accept);

    assign HTRANS    = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;
    assign busy      = ap_valid | dp_valid | hold_valid;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid   <= 1'b0;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HSIZE      <= '0;
            ap_wdata   <= '0;
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_addr_lo <= '0;
            dp_size    <= '0;
            HWDATA     <= '0;
            hold_valid <= 1'b0;
            hold_cmd   <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            // Address phase
            if (ap_load) begin
                ap_valid <= 1'b1;
                HADDR    <= ap_load_cmd.addr;
                HWRITE   <= ap_load_cmd.write;
                HSIZE    <= {1'b0, ap_load_cmd.size};
                ap_wdata <= ap_load_cmd.wdata;
            end else if (HREADY || err_first) begin
                ap_valid <= 1'b0;
            end

            // Cancelled address phase is parked and re-issued after the error
            if (err_first) begin
                hold_valid <= ap_valid;
                hold_cmd   <= ap_cmd;
            end else if (HREADY) begin
                hold_valid <= 1'b0;
            end

            // Data phase
            if (HREADY) begin
                dp_valid   <= ap_valid;
                dp_write   <= HWRITE;
                dp_addr_lo <= HADDR[1:0];
                dp_size    <= HSIZE[1:0];
                HWDATA     <= ap_wdata;
            end

            // Response
            rsp_valid <= HREADY & dp_valid;
            rsp_err   <= HREADY & dp_valid & HRESP;
            rsp_rdata <= (HREADY && dp_valid && !dp_write) ? lane_rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_lite_cmd_master.sv
module tb_mfp_ahb_lite_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [1:0]  cmd_size;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HBURST, HSIZE;
    logic        HMASTLOCK, HWRITE, HREADY, HRESP;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    mfp_ahb_lite_cmd_master u_dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .HADDR     (HADDR),
        .HBURST    (HBURST),
        .HMASTLOCK (HMASTLOCK),
        .HPROT     (HPROT),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

`ifdef MFP_AHB_MASTER_LANES_EN
    localparam bit LANES = 1'b1;
`else
    localparam bit LANES = 1'b0;
`endif

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } tcmd_t;

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;

    // Stimulus driver state
    logic        drv_valid = 1'b0, drv_write = 1'b0, accepted = 1'b0;
    logic [31:0] drv_addr = '0, drv_wdata = '0;
    logic [1:0]  drv_size = '0;
    logic        rand_mode = 1'b0;

    // Reference model: accepted commands whose address phase has not completed
    tcmd_t acc_q[$];
    logic  held = 1'b0;

    // Slave model and its current data phase
    logic        s_active = 1'b0, s_err1 = 1'b0;
    tcmd_t       s_cmd;
    int          s_wait = 0;
    logic [31:0] mem [logic [31:0]];

    logic        rsp_due = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        prev_wait_ap = 1'b0;
    logic [31:0] prev_haddr = '0;

    // Logs for directed checks
    int          acc_cyc[$], rsp_cyc[$];
    logic [31:0] obs_rdata[$];
    logic        obs_err[$];
    logic [31:0] last_haddr = '0, last_hwdata = '0;
    logic [2:0]  last_hsize = '0;
    int          ready_low = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic tcmd_t expect_cmd(logic w, logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
        tcmd_t c;
        int unsigned nbytes;
        c.write = w;
        c.size  = (sz == 2'd3) ? 2'd2 : sz;
        nbytes  = 1 << c.size;
        c.addr  = a - (a % nbytes);
        c.wdata = wd;
        if (LANES && c.size == 2'd0) c.wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
        if (LANES && c.size == 2'd1) c.wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
        return c;
    endfunction

    function automatic logic [31:0] rd_expect(logic [31:0] word, logic [31:0] a, logic [1:0] sz);
        longint unsigned v;
        v = 64'(word) >> (8 * a[1:0]);
        v = v & ((64'd1 << (8 << sz)) - 64'd1);
        return LANES ? v[31:0] : word;
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] k);
        return mem.exists(k) ? mem[k] : ((k * 32'h9E37_79B1) ^ 32'h1234_5678);
    endfunction

    function automatic logic err_addr(logic [31:0] a);
        return (a[15:12] == 4'hE) || (a == 32'h30);
    endfunction

    function automatic int wait_for(logic [31:0] a);
        if (a == 32'h20) return 2;
        if (rand_mode && $urandom_range(0, 3) == 0) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    // One clock cycle: drive slave and command inputs, check outputs, advance model.
    task automatic step();
        tcmd_t      c;
        logic       errf, exp_ready;
        logic [1:0] exp_trans;
        @(posedge HCLK);
        cyc++;
        #1;
        if (s_active && s_wait > 0) begin
            HREADY = 1'b0; HRESP = 1'b0;
        end else if (s_active && err_addr(s_cmd.addr)) begin
            HREADY = s_err1; HRESP = 1'b1;
        end else begin
            HREADY = 1'b1; HRESP = 1'b0;
        end
        HRDATA    = (s_active && !s_cmd.write) ? mem_rd(s_cmd.addr & ~32'h3) : $urandom();
        cmd_valid = drv_valid;
        cmd_write = drv_write;
        cmd_addr  = drv_addr;
        cmd_size  = drv_size;
        cmd_wdata = drv_wdata;
        #1;

        chk("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
        if (rsp_valid && rsp_due) begin
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            rsp_cyc.push_back(cyc);
            obs_rdata.push_back(rsp_rdata);
            obs_err.push_back(rsp_err);
        end
        errf      = s_active && HRESP && !HREADY;
        exp_trans = (acc_q.size() > 0 && !held) ? 2'b10 : 2'b00;
        exp_ready = !errf && !held && (acc_q.size() == 0 || HREADY);
        chk("htrans", 32'(HTRANS), 32'(exp_trans));
        chk("busy", 32'(busy), 32'(acc_q.size() > 0 || s_active));
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        if (prev_wait_ap) chk("addr_stable", HADDR, prev_haddr);
        prev_wait_ap = !HREADY && !errf && exp_trans == 2'b10;
        prev_haddr   = HADDR;
        if (cmd_valid && !cmd_ready) ready_low++;

        // Events of the coming clock edge
        rsp_due = 1'b0;
        if (s_active) begin
            if (HREADY) begin
                if (s_cmd.write) begin
                    chk("hwdata", HWDATA, s_cmd.wdata);
                    last_hwdata = HWDATA;
                    if (!HRESP) mem[s_cmd.addr & ~32'h3] = s_cmd.wdata;
                end
                rsp_due   = 1'b1;
                exp_err   = HRESP;
                exp_rdata = s_cmd.write ? 32'h0 : rd_expect(HRDATA, s_cmd.addr, s_cmd.size);
                s_active  = 1'b0;
            end else if (s_wait > 0) begin
                s_wait--;
            end else begin
                s_err1 = 1'b1;
            end
        end
        if (HREADY && acc_q.size() > 0 && !held) begin
            c = acc_q.pop_front();
            chk("haddr", HADDR, c.addr);
            chk("hwrite", 32'(HWRITE), 32'(c.write));
            chk("hsize", 32'(HSIZE), {30'h0, c.size});
            last_haddr = HADDR;
            last_hsize = HSIZE;
            s_active   = 1'b1;
            s_cmd      = c;
            s_wait     = wait_for(c.addr);
            s_err1     = 1'b0;
        end
        if (errf && acc_q.size() > 0) held = 1'b1;
        else if (HREADY) held = 1'b0;
        accepted = cmd_valid && cmd_ready;
        if (accepted) begin
            acc_q.push_back(expect_cmd(cmd_write, cmd_addr, cmd_size, cmd_wdata));
            acc_cyc.push_back(cyc);
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd);
        drv_valid = 1'b1; drv_write = w; drv_addr = a; drv_size = sz; drv_wdata = wd;
        accepted = 1'b0;
        for (int i = 0; i < 100 && !accepted; i++) step();
        chk("accept", 32'(accepted), 32'd1);
        drv_valid = 1'b0;
    endtask

    task automatic drain();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            step();
            idle = acc_q.size() == 0 && !s_active && !held && !rsp_due;
        end
        chk("drain", 32'(idle), 32'd1);
    endtask

    task automatic clear_logs();
        acc_cyc.delete(); rsp_cyc.delete(); obs_rdata.delete(); obs_err.delete();
        ready_low = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        #3;
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp", {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("hburst", 32'(HBURST), 32'd0);
        chk("hprot", 32'(HPROT), 32'h3);
        chk("hmastlock", 32'(HMASTLOCK), 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        // Back-to-back zero-wait: W 0x10, R 0x10, R 0x14
        clear_logs();
        send(1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF);
        send(1'b0, 32'h10, 2'd2, 32'h0);
        send(1'b0, 32'h14, 2'd2, 32'h0);
        drain();
        chk("t1_nrsp", 32'(obs_rdata.size()), 32'd3);
        if (obs_rdata.size() == 3 && acc_cyc.size() == 3) begin
            chk("t1_latency", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd3);
            chk("t1_acc_b2b", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
            chk("t1_rsp_b2b", 32'(rsp_cyc[2] - rsp_cyc[0]), 32'd2);
            chk("t1_rdata", obs_rdata[1], 32'hDEAD_BEEF);
            chk("t1_err", 32'({obs_err[0], obs_err[1], obs_err[2]}), 32'd0);
        end

        // Two wait states on the read of 0x20 with further commands pending
        clear_logs();
        send(1'b0, 32'h20, 2'd2, 32'h0);
        send(1'b0, 32'h24, 2'd2, 32'h0);
        send(1'b0, 32'h28, 2'd2, 32'h0);
        drain();
        chk("t2_nrsp", 32'(obs_rdata.size()), 32'd3);
        chk("t2_ready_low", 32'(ready_low >= 2), 32'd1);

        // ERROR on write to 0x30 with read of 0x34 queued behind it
        clear_logs();
        send(1'b1, 32'h30, 2'd2, 32'h1234_5678);
        send(1'b0, 32'h34, 2'd2, 32'h0);
        drain();
        chk("t3_nrsp", 32'(obs_err.size()), 32'd2);
        if (obs_err.size() == 2) begin
            chk("t3_err_wr", 32'(obs_err[0]), 32'd1);
            chk("t3_err_rd", 32'(obs_err[1]), 32'd0);
        end

        // Unaligned word address
        send(1'b0, 32'h43, 2'd2, 32'h0);
        drain();
        chk("t4_haddr", last_haddr, 32'h40);
        chk("t4_hsize", 32'(last_hsize), 32'd2);

`ifdef MFP_AHB_MASTER_LANES_EN
        clear_logs();
        mem[32'h40] = 32'hAABB_CCDD;
        send(1'b0, 32'h42, 2'd0, 32'h0);
        drain();
        chk("t5_byte_rd", obs_rdata[0], 32'h0000_00BB);
        send(1'b1, 32'h42, 2'd0, 32'h0000_005A);
        drain();
        chk("t5_byte_wr", last_hwdata, 32'h5A5A_5A5A);
`endif

        // Asynchronous reset in the middle of a wait state
        send(1'b0, 32'h20, 2'd2, 32'h0);
        send(1'b0, 32'h24, 2'd2, 32'h0);
        step();
        chk("t6_pre_busy", 32'(busy), 32'd1);
        #2;
        HRESETn = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("t6_htrans", 32'(HTRANS), 32'd0);
        chk("t6_haddr", HADDR, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rsp", 32'(rsp_valid), 32'd0);
        chk("t6_ready", 32'(cmd_ready), 32'd1);
        acc_q.delete();
        s_active = 1'b0; held = 1'b0; rsp_due = 1'b0; prev_wait_ap = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (6) step();

        // Randomised traffic: waits, errors, mixed sizes, bursty valid
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!drv_valid || accepted) begin
                drv_valid = ($urandom_range(0, 3) != 0);
                drv_write = $urandom_range(0, 1) == 1;
                drv_size  = 2'($urandom_range(0, 3));
                drv_wdata = $urandom();
                drv_addr  = ($urandom_range(0, 7) == 0) ? {16'h0, 4'hE, 12'($urandom())}
                                                        : {20'h0, 12'($urandom())};
            end
            step();
        end
        drv_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
